parity_frame_gen: RTL and testbench



---
 rtl/parity_frame_gen.sv | 124 ++++++++++++
 tb/tb_parity_frame_gen.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/parity_frame_gen.sv
// Streaming even/odd parity generator/checker: accumulates parity over a frame of
// up to MAX_FRAME words and emits one registered result beat per frame.
module parity_frame_gen #(
    parameter  int unsigned DATA_W    = 8,
    parameter  int unsigned MAX_FRAME = 16,
    localparam int unsigned CNT_W     = $clog2(MAX_FRAME + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    input  logic              last_in,
    input  logic              odd_in,
    input  logic              check_in,
    input  logic              parity_in,
    output logic              ready_out,
    output logic              valid_out,
    input  logic              ready_in,
    output logic              parity_out,
    output logic [CNT_W-1:0]  frame_len_out,
    output logic              error_out,
    output logic              trunc_out
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_FRAME);

    typedef enum logic {ACCUM, EMIT} state_t;

    state_t           r_state, w_state_nxt;
    logic             r_acc, w_acc_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
    logic             r_odd, w_odd_nxt, w_odd;
    logic             r_check, w_check_nxt, w_check;
    logic             r_ready, r_valid;
    logic             r_parity, w_parity_nxt;
    logic [CNT_W-1:0] r_len, w_len_nxt;
    logic             r_err, w_err_nxt;
    logic             r_trunc, w_trunc_nxt;
    logic             w_accept, w_first;

    assign w_accept  = r_ready & valid_in;
    assign w_first   = (r_cnt == '0);
    assign w_cnt_inc = r_cnt + CNT_W'(1);
    // Mode bits take effect on the first word itself so single-word frames work.
    assign w_odd     = w_first ? odd_in   : r_odd;
    assign w_check   = w_first ? check_in : r_check;

    always_comb begin
        w_state_nxt  = r_state;
        w_acc_nxt    = r_acc;
        w_cnt_nxt    = r_cnt;
        w_odd_nxt    = r_odd;
        w_check_nxt  = r_check;
        w_parity_nxt = r_parity;
        w_len_nxt    = r_len;
        w_err_nxt    = r_err;
        w_trunc_nxt  = r_trunc;
        case (r_state)
            ACCUM: begin
                if (w_accept) begin
                    w_acc_nxt   = r_acc ^ (^data_in);
                    w_cnt_nxt   = w_cnt_inc;
                    w_odd_nxt   = w_odd;
                    w_check_nxt = w_check;
                    if (last_in || (w_cnt_inc == MAX_CNT)) begin
                        w_state_nxt  = EMIT;
                        w_parity_nxt = w_acc_nxt ^ w_odd;
                        w_len_nxt    = w_cnt_inc;
                        w_err_nxt    = w_check & (parity_in ^ w_parity_nxt);
                        w_trunc_nxt  = ~last_in;
                    end
                end
            end
            EMIT: begin
                if (ready_in) begin
                    w_state_nxt  = ACCUM;
                    w_acc_nxt    = 1'b0;
                    w_cnt_nxt    = '0;
                    w_parity_nxt = 1'b0;
                    w_len_nxt    = '0;
                    w_err_nxt    = 1'b0;
                    w_trunc_nxt  = 1'b0;
                end
            end
            default: w_state_nxt = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ACCUM;
            r_acc    <= 1'b0;
            r_cnt    <= '0;
            r_odd    <= 1'b0;
            r_check  <= 1'b0;
            r_ready  <= 1'b0;
            r_valid  <= 1'b0;
            r_parity <= 1'b0;
            r_len    <= '0;
            r_err    <= 1'b0;
            r_trunc  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_acc    <= w_acc_nxt;
            r_cnt    <= w_cnt_nxt;
            r_odd    <= w_odd_nxt;
            r_check  <= w_check_nxt;
            r_ready  <= (w_state_nxt == ACCUM);
            r_valid  <= (w_state_nxt == EMIT);
            r_parity <= w_parity_nxt;
            r_len    <= w_len_nxt;
            r_err    <= w_err_nxt;
            r_trunc  <= w_trunc_nxt;
        end
    end

    assign ready_out     = r_ready;
    assign valid_out     = r_valid;
    assign parity_out    = r_parity;
    assign frame_len_out = r_len;
    assign error_out     = r_err;
    assign trunc_out     = r_trunc;

endmodule

// File: tb/tb_parity_frame_gen.sv
// Bench for parity_frame_gen: directed frames, a ones-counting reference model
// compared every cycle, plus literal expectations for each directed frame.
module tb_parity_frame_gen;

    localparam int unsigned DATA_W    = 8;
    localparam int unsigned MAX_FRAME = 16;
    localparam int unsigned CNT_W     = $clog2(MAX_FRAME + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] data_in;
    logic              valid_in, last_in, odd_in, check_in, parity_in;
    logic              ready_out, valid_out, ready_in;
    logic              parity_out, error_out, trunc_out;
    logic [CNT_W-1:0]  frame_len_out;

    parity_frame_gen #(.DATA_W(DATA_W), .MAX_FRAME(MAX_FRAME)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
        .last_in(last_in), .odd_in(odd_in), .check_in(check_in),
        .parity_in(parity_in), .ready_out(ready_out), .valid_out(valid_out),
        .ready_in(ready_in), .parity_out(parity_out),
        .frame_len_out(frame_len_out), .error_out(error_out),
        .trunc_out(trunc_out)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit run_cmp = 1'b0;

    task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: counts ones over the frame; predicts ready/valid/result.
    bit          m_rdy = 1'b0, m_pend = 1'b0, m_odd = 1'b0, m_chk = 1'b0;
    int unsigned m_len = 0, m_ones = 0;
    bit          e_par = 1'b0, e_err = 1'b0, e_trunc = 1'b0;
    int unsigned e_len = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_len = 0; m_ones = 0; m_pend = 1'b0;
            e_par = 1'b0; e_len = 0; e_err = 1'b0; e_trunc = 1'b0;
        end else if (m_pend) begin
            if (ready_in) begin
                m_pend = 1'b0;
                e_par = 1'b0; e_len = 0; e_err = 1'b0; e_trunc = 1'b0;
            end
        end else if (m_rdy && valid_in) begin
            if (m_len == 0) begin
                m_odd = odd_in;
                m_chk = check_in;
            end
            m_len++;
            m_ones += $countones(data_in);
            if (last_in || m_len == MAX_FRAME) begin
                e_par   = ((m_ones % 2) == 1) ^ m_odd;
                e_len   = m_len;
                e_err   = m_chk && (parity_in != e_par);
                e_trunc = !last_in;
                m_pend  = 1'b1;
                m_len   = 0;
                m_ones  = 0;
            end
        end
        m_rdy = !rst && !m_pend;
    end

    always @(negedge clk) begin
        logic [CNT_W+4:0] exp_v, act_v;
        if (run_cmp) begin
            exp_v = {m_rdy, m_pend, e_par, CNT_W'(e_len), e_err, e_trunc};
            act_v = {ready_out, valid_out, parity_out, frame_len_out, error_out, trunc_out};
            chk("model", int'(act_v), int'(exp_v));
        end
    end

    // Called and returns at posedge+1.
    task automatic send(input logic [DATA_W-1:0] d, input logic l, input logic o,
                        input logic c, input logic p, output int waited);
        logic rd;
        data_in = d; last_in = l; odd_in = o; check_in = c; parity_in = p;
        valid_in = 1'b1;
        waited = 0;
        rd = 1'b0;
        for (int t = 0; t < 64; t++) begin
            @(negedge clk);
            rd = ready_out;
            @(posedge clk);
            #1;
            if (rd) break;
            waited++;
        end
        chk("send_accept", rd, 1);
        valid_in = 1'b0;
    endtask

    // Checks the result beat for hold+1 cycles, then handshakes; returns at posedge+1.
    task automatic wait_result(input int hold, input logic p, input int unsigned len,
                               input logic e, input logic tr, input string nm);
        for (int h = 0; h <= hold; h++) begin
            @(negedge clk);
            chk({nm, "_valid"}, valid_out, 1);
            chk({nm, "_ready"}, ready_out, 0);
            chk({nm, "_parity"}, parity_out, p);
            chk({nm, "_len"}, frame_len_out, len);
            chk({nm, "_err"}, error_out, e);
            chk({nm, "_trunc"}, trunc_out, tr);
        end
        ready_in = 1'b1;
        @(posedge clk);
        #1;
        ready_in = 1'b0;
    endtask

    initial begin
        int w;
        rst = 1'b1; valid_in = 1'b0; last_in = 1'b0; odd_in = 1'b0;
        check_in = 1'b0; parity_in = 1'b0; data_in = '0; ready_in = 1'b0;
        run_cmp = 1'b1;

        // Reset / idle
        repeat (3) begin
            @(negedge clk);
            chk("rst_ready", ready_out, 0);
            chk("rst_valid", valid_out, 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_rst_ready", ready_out, 1);
        @(posedge clk); #1;

        // Even generate: 0x01,0x03,0xFF; mode bits on later words must be ignored
        send(8'h01, 0, 0, 0, 1, w);
        send(8'h03, 0, 1, 1, 1, w);
        send(8'hFF, 1, 1, 1, 0, w);
        wait_result(0, 1, 3, 0, 0, "even3");
        send(8'h10, 1, 0, 0, 0, w);
        chk("bubble_one_cycle", w, 0);
        wait_result(0, 1, 1, 0, 0, "single10");

        // Odd check, single word
        send(8'hA5, 1, 1, 1, 0, w);
        wait_result(0, 1, 1, 1, 0, "odd_chk_err");
        send(8'hA5, 1, 1, 1, 1, w);
        wait_result(0, 1, 1, 0, 0, "odd_chk_ok");

        // Truncation at MAX_FRAME; 17th word held off while in EMIT
        for (int i = 0; i < 16; i++) send(8'h01, 0, 0, 0, 0, w);
        data_in = 8'h01; last_in = 1'b1; odd_in = 1'b0; check_in = 1'b0;
        parity_in = 1'b0; valid_in = 1'b1;
        wait_result(2, 0, 16, 0, 1, "trunc");
        send(8'h01, 1, 0, 0, 0, w);
        chk("word17_next_cycle", w, 0);
        wait_result(0, 1, 1, 0, 0, "word17");

        // Backpressure: result held 5 extra cycles
        send(8'h0F, 0, 1, 1, 0, w);
        send(8'hF0, 1, 0, 0, 1, w);
        wait_result(5, 1, 2, 0, 0, "bp");
        send(8'h55, 1, 0, 1, 1, w);
        chk("bp_next_accept", w, 0);
        wait_result(0, 0, 1, 1, 0, "bp_next");

        // Reset mid-frame discards the partial frame
        send(8'h03, 0, 0, 0, 0, w);
        send(8'h01, 0, 0, 0, 0, w);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_valid", valid_out, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        send(8'h07, 1, 0, 0, 0, w);
        wait_result(0, 1, 1, 0, 0, "after_rst");

        repeat (3) @(negedge clk);
        run_cmp = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
